// File: rtl/count_capture.sv
// count_capture: timestamps rising edges of evt with {wrap epoch, counter value}
// and queues them in a small FIFO for a valid/ready consumer. It also emits
// registered wrap and compare-match pulses derived from the upstream 4-bit count.
// Latency: wrap/match/captures become visible the cycle after the triggering edge.
// Backpressure: rd_ready low holds the head entry; a capture into a full FIFO
// with no simultaneous pop is dropped and latches the sticky ovf flag.

module count_capture #(
  parameter int DEPTH   = 4,   // FIFO entries, power of two in 2..16
  parameter int EPOCH_W = 3    // width of the wrap-epoch counter
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 cnt,
  input  logic                       evt,
  input  logic                       cmp_en,
  input  logic [3:0]                 cmp_val,
  input  logic                       rd_ready,
  input  logic                       ovf_clr,
  output logic                       rd_valid,
  output logic [EPOCH_W+3:0]         rd_data,
  output logic                       wrap,
  output logic                       match,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DATA_W = EPOCH_W + 4;

  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]     LVL_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]     LVL_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

  // ------------------------------------------------------------------
  // Input history and derived events
  // ------------------------------------------------------------------
  logic [3:0]         cnt_q;
  logic               evt_q;
  logic [EPOCH_W-1:0] epoch;

  logic wrap_hit;   // this edge sees the 15 -> 0 rollover
  logic match_hit;  // this edge sees a fresh arrival at cmp_val
  logic rise;       // this edge sees evt go from low to high

  // Only the exact 15->0 step counts as a wrap; skips, holds and
  // backward steps are ignored so the epoch tracks true laps.
  assign wrap_hit  = (cnt_q == 4'd15) && (cnt == 4'd0);

  // Requiring cnt to have changed keeps a held count from re-firing.
  assign match_hit = cmp_en && (cnt == cmp_val) && (cnt != cnt_q);

  assign rise      = evt && !evt_q;

  // Register the previous count and trigger level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt;
      evt_q <= evt;
    end
  end

  // Epoch counter advances once per counter lap and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch <= '0;
    end else if (wrap_hit) begin
      epoch <= epoch + EPOCH_ONE;
    end
  end

  // Registered single-cycle wrap and match pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap  <= 1'b0;
      match <= 1'b0;
    end else begin
      wrap  <= wrap_hit;
      match <= match_hit;
    end
  end

  // ------------------------------------------------------------------
  // Capture FIFO
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              full;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [DATA_W-1:0] push_dat;

  // The captured epoch is the register value, i.e. before any increment
  // happening on this same edge.
  assign push_dat = {epoch, cnt};

  assign full     = (level == LVL_FULL);
  assign rd_valid = (level != '0);
  assign pop      = rd_valid && rd_ready;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok  = rise && (!full || pop);
  assign drop     = rise && full && !pop;

  // No bypass path: the head is always read from storage, so a new entry
  // becomes visible only after the edge that wrote it.
  assign rd_data  = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap modulo DEPTH by virtue of DEPTH being a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Occupancy: push_ok never fires into a full FIFO without a pop, and pop
  // never fires when empty, so level stays within 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      unique case ({push_ok, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a drop on the same edge as ovf_clr keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: drives counter/trigger patterns with
// hand-computed expectations for wrap, match, capture order, overflow and reset.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.

module tb_count_capture;

  localparam int DEPTH   = 4;
  localparam int EPOCH_W = 3;

  logic                   clk;
  logic                   rst;
  logic [3:0]             cnt;
  logic                   evt;
  logic                   cmp_en;
  logic [3:0]             cmp_val;
  logic                   rd_ready;
  logic                   ovf_clr;
  logic                   rd_valid;
  logic [EPOCH_W+3:0]     rd_data;
  logic                   wrap;
  logic                   match;
  logic                   ovf;
  logic [$clog2(DEPTH):0] level;

  int checks;
  int errors;

  count_capture #(
    .DEPTH   (DEPTH),
    .EPOCH_W (EPOCH_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .evt      (evt),
    .cmp_en   (cmp_en),
    .cmp_val  (cmp_val),
    .rd_ready (rd_ready),
    .ovf_clr  (ovf_clr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wrap     (wrap),
    .match    (match),
    .ovf      (ovf),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse evt for one cycle at count v, then drop it for one cycle.
  task automatic pulse_evt(input logic [3:0] v);
    cnt = v;
    evt = 1'b1;
    tick();
    evt = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    cnt      = 4'd0;
    evt      = 1'b0;
    cmp_en   = 1'b0;
    cmp_val  = 4'd0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;
    #2;
    rst      = 1'b0;
  endtask

  initial begin
    int mcount;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    cnt      = 4'd0;
    evt      = 1'b0;
    cmp_en   = 1'b0;
    cmp_val  = 4'd0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;

    // Reset state
    #12;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_level",    32'(level),    32'd0);
    check("rst_wrap",     32'(wrap),     32'd0);
    check("rst_match",    32'(match),    32'd0);
    check("rst_ovf",      32'(ovf),      32'd0);

    // Free-running lap: match after cnt=5, wrap after 15->0, epoch 0->1
    do_reset();
    cmp_en  = 1'b1;
    cmp_val = 4'd5;
    for (int i = 0; i < 18; i++) begin
      cnt = 4'(i % 16);
      tick();
      check("lap_match", 32'(match), 32'((i % 16) == 5));
      check("lap_wrap",  32'(wrap),  32'(i == 16));
    end
    // Skip from 15 to 2 is not a wrap
    cnt = 4'd15;
    tick();
    cnt = 4'd2;
    tick();
    check("skip_no_wrap", 32'(wrap), 32'd0);
    // Capture shows epoch 1 (one true wrap only)
    evt = 1'b1;
    tick();
    evt = 1'b0;
    check("epoch1_level", 32'(level),   32'd1);
    check("epoch1_data",  32'(rd_data), 32'h12);
    rd_ready = 1'b1;
    tick();
    check("epoch1_empty", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    // Captures at cnt=3 and cnt=9, then drain in order
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cnt = 4'(i);
      evt = (i == 3) || (i == 9);
      tick();
    end
    evt = 1'b0;
    check("two_level", 32'(level),    32'd2);
    check("two_valid", 32'(rd_valid), 32'd1);
    check("two_head",  32'(rd_data),  32'h03);
    tick();
    check("two_hold",  32'(rd_data),  32'h03);
    rd_ready = 1'b1;
    tick();
    check("two_pop1_data",  32'(rd_data), 32'h09);
    check("two_pop1_level", 32'(level),   32'd1);
    tick();
    check("two_pop2_valid", 32'(rd_valid), 32'd0);
    check("two_pop2_level", 32'(level),    32'd0);
    rd_ready = 1'b0;

    // Overflow: six rises into a 4-deep FIFO
    do_reset();
    for (int v = 1; v <= 4; v++) pulse_evt(4'(v));
    check("full_level", 32'(level),   32'd4);
    check("full_ovf",   32'(ovf),     32'd0);
    check("full_head",  32'(rd_data), 32'd1);
    pulse_evt(4'd5);
    check("drop5_ovf",   32'(ovf),   32'd1);
    check("drop5_level", 32'(level), 32'd4);
    pulse_evt(4'd6);
    check("drop6_ovf",   32'(ovf),   32'd1);
    // Drop coinciding with ovf_clr keeps the flag
    cnt     = 4'd7;
    evt     = 1'b1;
    ovf_clr = 1'b1;
    tick();
    check("setwins_ovf", 32'(ovf), 32'd1);
    evt = 1'b0;
    tick();
    ovf_clr = 1'b0;
    check("clr_ovf",   32'(ovf),   32'd0);
    check("clr_level", 32'(level), 32'd4);
    rd_ready = 1'b1;
    check("keep_1", 32'(rd_data), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("keep_k", 32'(rd_data), 32'(k));
    end
    tick();
    check("keep_empty", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    // Simultaneous push/pop at partial and full occupancy
    do_reset();
    pulse_evt(4'd1);
    pulse_evt(4'd2);
    cnt      = 4'd3;
    evt      = 1'b1;
    rd_ready = 1'b1;
    tick();
    evt      = 1'b0;
    rd_ready = 1'b0;
    check("mid_pp_level", 32'(level),   32'd2);
    check("mid_pp_head",  32'(rd_data), 32'd2);
    tick();
    pulse_evt(4'd4);
    pulse_evt(4'd5);
    check("pp_full_level", 32'(level), 32'd4);
    cnt      = 4'd7;
    evt      = 1'b1;
    rd_ready = 1'b1;
    tick();
    evt = 1'b0;
    check("full_pp_level", 32'(level),   32'd4);
    check("full_pp_ovf",   32'(ovf),     32'd0);
    check("full_pp_head",  32'(rd_data), 32'd3);
    tick();
    check("full_pp_d4", 32'(rd_data), 32'd4);
    tick();
    check("full_pp_d5", 32'(rd_data), 32'd5);
    tick();
    check("full_pp_d7", 32'(rd_data), 32'd7);
    tick();
    check("full_pp_empty", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    // Held evt captures once; held compare value matches once
    do_reset();
    cnt = 4'd8;
    evt = 1'b1;
    repeat (10) tick();
    evt = 1'b0;
    tick();
    check("held_evt_level", 32'(level),   32'd1);
    check("held_evt_data",  32'(rd_data), 32'd8);
    cmp_en  = 1'b1;
    cmp_val = 4'd6;
    cnt     = 4'd6;
    mcount  = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) check("held_cmp_first", 32'(match), 32'd1);
      mcount += int'(match);
    end
    check("held_cmp_count", 32'(mcount), 32'd1);
    cmp_en = 1'b0;

    // Mid-stream reset with epoch 1 and three entries
    do_reset();
    cnt = 4'd15;
    tick();
    cnt = 4'd0;
    tick();
    check("r_wrap", 32'(wrap), 32'd1);
    pulse_evt(4'd1);
    pulse_evt(4'd2);
    pulse_evt(4'd3);
    check("r_level", 32'(level),   32'd3);
    check("r_head",  32'(rd_data), 32'h11);
    #2;
    rst = 1'b1;
    #1;
    check("r_async_valid", 32'(rd_valid), 32'd0);
    check("r_async_level", 32'(level),    32'd0);
    check("r_async_ovf",   32'(ovf),      32'd0);
    cnt = 4'd5;
    evt = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    evt = 1'b0;
    check("r_first_level", 32'(level),   32'd1);
    check("r_first_data",  32'(rd_data), 32'h05);
    check("r_first_wrap",  32'(wrap),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, capture FIFO entry count; power of two, 2..16.
REQ-002 The block SHALL have parameter EPOCH_W, default 3, width of the wrap-epoch counter.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port cnt  input  4  count value from the upstream 4-bit synchronous up counter, synchronous to clk.
REQ-006 The block SHALL have port evt  input  1  capture trigger level, synchronous to clk.
REQ-007 The block SHALL have port cmp_en  input  1  compare enable.
REQ-008 The block SHALL have port cmp_val  input  4  compare value.
REQ-009 The block SHALL have port rd_ready  input  1  consumer ready.
REQ-010 The block SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-011 The block SHALL have port rd_valid  output  1  FIFO head entry valid.
REQ-012 The block SHALL have port rd_data  output  EPOCH_W+4  head entry, {epoch, cnt}.
REQ-013 The block SHALL have port wrap  output  1  one-cycle pulse on counter wrap.
REQ-014 The block SHALL have port match  output  1  one-cycle compare pulse.
REQ-015 The block SHALL have port ovf  output  1  sticky capture-dropped flag.
REQ-016 The block SHALL have port level  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Function
REQ-017 The block SHALL register cnt each cycle as cnt_q (previous value).
REQ-018 Wrap: a registered wrap output SHALL be high for exactly the cycle after a clock edge where cnt_q==15 and cnt==0; epoch SHALL increment modulo 2^EPOCH_W on that same edge.
REQ-019 No other cnt transition (hold, skip, backward step) SHALL produce wrap or change epoch.
REQ-020 Match: registered match SHALL be high for one cycle after an edge where cmp_en==1, cnt==cmp_val and cnt!=cnt_q; a held count SHALL produce only one pulse.
REQ-021 Capture: evt SHALL be registered as evt_q; rise = evt & ~evt_q; a level held high SHALL capture once.
REQ-022 On an edge with rise, the block SHALL push {epoch, cnt}, using epoch before any same-edge increment.
REQ-023 Handshake: a pop SHALL occur on an edge where rd_valid && rd_ready; rd_data SHALL be stable while rd_valid is high and rd_ready is low.
REQ-024 rd_valid SHALL equal (level != 0); rd_data SHALL present the oldest entry in first-in first-out order.
REQ-025 Latency: an entry pushed into an empty FIFO at edge N SHALL be visible on rd_valid/rd_data after edge N; there is no bypass within the same cycle.
REQ-026 Full: a push when level==DEPTH with no pop on the same edge SHALL be dropped and SHALL set ovf; FIFO contents SHALL be unchanged.
REQ-027 A push and pop on the same edge when full SHALL both succeed, with level unchanged and no ovf.
REQ-028 A push and pop on the same edge when 0 < level < DEPTH SHALL leave level unchanged.
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 ovf_clr SHALL clear ovf; if a drop occurs on the same edge, ovf SHALL stay 1 (set wins).
REQ-031 level SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-032 While rst is high, all state SHALL clear asynchronously: rd_valid=0, level=0, wrap=0, match=0, ovf=0, epoch=0, cnt_q=0, evt_q=0, pointers=0.
REQ-033 rd_data SHALL be don't-care while rd_valid==0.
REQ-034 Reset asserted mid-operation SHALL discard all FIFO entries.
REQ-035 The first edge after reset release SHALL behave normally; an evt already high at release SHALL count as a rise.

Verification
REQ-036 Counter 0..15..0 free-running, cmp_en=1, cmp_val=5 -> match pulses once per lap one cycle after cnt=5 edge; wrap pulses after 15->0; epoch 0->1.
REQ-037 evt pulses at cnt=3 and cnt=9, rd_ready=0 -> level=2, rd_data=0x03; then rd_ready=1 -> 0x03, 0x09 popped in order, then rd_valid=0.
REQ-038 Six evt rises with rd_ready=0, DEPTH=4 -> level=4, ovf=1 after 5th rise, first four values retained; ovf_clr -> ovf=0.
REQ-039 FIFO full, rd_ready=1 and evt rise same edge -> level stays 4, ovf stays 0, new entry appears last.
REQ-040 evt held high 10 cycles -> exactly one entry; cnt held at cmp_val for 5 cycles -> exactly one match.
REQ-041 rst asserted with level=3 mid-stream -> immediately rd_valid=0, level=0, epoch=0; after release, first capture has epoch 0.
